// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide engine for the EX stage.
// Runs 32 iterations for MULT/MULTU/DIV/DIVU and presents a registered {HI,LO} result.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        valid,
  input  logic        flush,
  input  logic        stall_in,
  output logic        stall_o,
  output logic        hilo_valid,
  output logic [63:0] hilo_out
);

  // Operation codes shared with the decode stage.
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'd10;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd11;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'd12;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic [31:0] src_a_q, src_a_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] hilo_q, hilo_d;
  logic        hilo_valid_q, hilo_valid_d;

  logic        is_md_s, op_signed_s, op_div_s, start_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] mul_sum_s, rem_sh_s;
  logic [31:0] div_diff_s, rem_nxt_s;
  logic        div_ge_s;
  logic [63:0] step_s, fin_s;

  // Decode the operation code and form operand magnitudes for the issue cycle.
  always_comb begin
    is_md_s     = 1'b0;
    op_signed_s = 1'b0;
    op_div_s    = 1'b0;
    case (alu_control)
      ALU_SIGNED_MULT:   begin is_md_s = 1'b1; op_signed_s = 1'b1; end
      ALU_UNSIGNED_MULT: begin is_md_s = 1'b1; end
      ALU_SIGNED_DIV:    begin is_md_s = 1'b1; op_signed_s = 1'b1; op_div_s = 1'b1; end
      ALU_UNSIGNED_DIV:  begin is_md_s = 1'b1; op_div_s = 1'b1; end
      default:           begin is_md_s = 1'b0; end
    endcase
    start_s = valid & ~flush & (state_q == ST_IDLE) & is_md_s;
    mag_a_s = (op_signed_s && src_a[31]) ? (32'd0 - src_a) : src_a;
    mag_b_s = (op_signed_s && src_b[31]) ? (32'd0 - src_b) : src_b;
  end

  // One radix-2 iteration plus the sign/divide-by-zero fixup of the final value.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh_s   = {acc_q[63:32], acc_q[31]};
    div_ge_s   = (rem_sh_s >= {1'b0, opnd_q});
    div_diff_s = rem_sh_s[31:0] - opnd_q;
    rem_nxt_s  = div_ge_s ? div_diff_s : rem_sh_s[31:0];
    if (is_div_q) begin
      step_s = {rem_nxt_s, acc_q[30:0], div_ge_s};
    end else begin
      step_s = {mul_sum_s, acc_q[31:1]};
    end
    if (!is_div_q) begin
      fin_s = neg_res_q ? (64'd0 - step_s) : step_s;
    end else if (dbz_q) begin
      fin_s = {src_a_q, 32'hFFFF_FFFF};
    end else begin
      fin_s[63:32] = neg_rem_q ? (32'd0 - step_s[63:32]) : step_s[63:32];
      fin_s[31:0]  = neg_res_q ? (32'd0 - step_s[31:0])  : step_s[31:0];
    end
  end

  // Next-state, operand capture and result registration.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_div_d     = is_div_q;
    neg_res_d    = neg_res_q;
    neg_rem_d    = neg_rem_q;
    dbz_d        = dbz_q;
    src_a_d      = src_a_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    hilo_d       = hilo_q;
    hilo_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          is_div_d  = op_div_s;
          neg_res_d = op_signed_s & (src_a[31] ^ src_b[31]);
          neg_rem_d = op_signed_s & op_div_s & src_a[31];
          dbz_d     = op_div_s & (src_b == 32'd0);
          src_a_d   = src_a;
          opnd_d    = op_div_s ? mag_b_s : mag_a_s;
          acc_d     = {32'd0, op_div_s ? mag_a_s : mag_b_s};
          cnt_d     = 6'd0;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            hilo_d       = fin_s;
            hilo_valid_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (stall_in) begin
          hilo_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 6'd0;
      is_div_q     <= 1'b0;
      neg_res_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      dbz_q        <= 1'b0;
      src_a_q      <= 32'd0;
      opnd_q       <= 32'd0;
      acc_q        <= 64'd0;
      hilo_q       <= 64'd0;
      hilo_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      neg_res_q    <= neg_res_d;
      neg_rem_q    <= neg_rem_d;
      dbz_q        <= dbz_d;
      src_a_q      <= src_a_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      hilo_q       <= hilo_d;
      hilo_valid_q <= hilo_valid_d;
    end
  end

  // Stall must freeze EX in the issue cycle, so it is combinational.
  always_comb begin
    if (rst) begin
      stall_o = 1'b0;
    end else begin
      stall_o = start_s | (state_q == ST_RUN);
    end
  end

  assign hilo_valid = hilo_valid_q;
  assign hilo_out   = hilo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with a result scoreboard
// plus hand-written flush, stall_in and reset sequences.
module tb_muldiv_unit;

  localparam logic [4:0] OP_MULT  = 5'd10;
  localparam logic [4:0] OP_MULTU = 5'd11;
  localparam logic [4:0] OP_DIV   = 5'd12;
  localparam logic [4:0] OP_DIVU  = 5'd13;
  localparam int NV = 14;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alu_control;
  logic [31:0] src_a, src_b;
  logic        valid, flush, stall_in;
  logic        stall_o, hilo_valid;
  logic [63:0] hilo_out;

  vec_t        vecs [NV];
  logic [63:0] sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  muldiv_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .valid      (valid),
    .flush      (flush),
    .stall_in   (stall_in),
    .stall_o    (stall_o),
    .hilo_valid (hilo_valid),
    .hilo_out   (hilo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge and wait for DONE; checks stall length and result.
  task automatic issue_wait(input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    logic [63:0] e;
    @(negedge clk);
    valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    sb_q.push_back(exp);
    #1;
    chk("stall_cycle0", {63'd0, stall_o}, 64'd1);
    cyc = 0;
    while (stall_o && cyc < 100) begin
      cyc++;
      @(negedge clk); #1;
    end
    chk("stall_len", 64'(cyc), 64'd33);
    chk("done_valid", {63'd0, hilo_valid}, 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("result", hilo_out, e);
    end else begin
      chk("sb_empty", 64'd1, 64'd0);
    end
  endtask

  // Instruction leaves EX; the result must be a one-cycle pulse.
  task automatic retire();
    @(negedge clk);
    valid = 1'b0; alu_control = 5'd0;
    #1;
    chk("valid_drop", {63'd0, hilo_valid}, 64'd0);
    chk("idle_stall", {63'd0, stall_o}, 64'd0);
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{OP_MULT,  32'h0000_0003, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[1]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[2]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[3]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF};
    vecs[4]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[5]  = '{OP_DIV,   32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF};
    vecs[6]  = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF};
    vecs[7]  = '{OP_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006};
    vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    vecs[9]  = '{OP_MULTU, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[11] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E};
    vecs[12] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF};
    vecs[13] = '{OP_MULT,  32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};

    rst = 1'b1; valid = 1'b0; flush = 1'b0; stall_in = 1'b0;
    alu_control = 5'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_valid", {63'd0, hilo_valid}, 64'd0);
    chk("rst_hilo", hilo_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // A code the unit does not handle must not stall.
    @(negedge clk);
    valid = 1'b1; alu_control = 5'd2; src_a = 32'd5; src_b = 32'd6;
    #1;
    chk("nonmd_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk); #1;
    chk("nonmd_stall2", {63'd0, stall_o}, 64'd0);

    // Flush in the start cycle prevents the start.
    @(negedge clk);
    valid = 1'b1; alu_control = OP_MULT; flush = 1'b1;
    #1;
    chk("flush_start_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    valid = 1'b0; flush = 1'b0; alu_control = 5'd0;
    #1;
    chk("flush_start_idle", {63'd0, stall_o}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      issue_wait(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      retire();
    end

    // Flush at cycle 10 of a DIV.
    @(negedge clk);
    valid = 1'b1; alu_control = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    chk("flush_run_stall", {63'd0, stall_o}, 64'd1);
    flush = 1'b1; valid = 1'b0;
    @(negedge clk);
    flush = 1'b0; alu_control = 5'd0;
    #1;
    chk("flush_stall_low", {63'd0, stall_o}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (hilo_valid) seen = 1'b1;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);
    issue_wait(OP_MULT, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340);
    retire();

    // stall_in held in DONE with valid high: no restart, result held.
    issue_wait(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("hold_valid", {63'd0, hilo_valid}, 64'd1);
      chk("hold_no_restart", {63'd0, stall_o}, 64'd0);
      chk("hold_result", hilo_out, 64'h0000_0001_0000_0000);
      if (k == 2) stall_in = 1'b0;
    end
    retire();

    // Asynchronous reset mid-RUN clears outputs immediately.
    @(negedge clk);
    valid = 1'b1; alu_control = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_stall", {63'd0, stall_o}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", {63'd0, stall_o}, 64'd0);
    chk("midrst_valid", {63'd0, hilo_valid}, 64'd0);
    chk("midrst_hilo", hilo_out, 64'd0);
    @(negedge clk);
    valid = 1'b0; alu_control = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (hilo_valid || stall_o) seen = 1'b1;
    end
    chk("post_rst_quiet", {63'd0, seen}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
